// File: rtl/bcd_pkg.sv
// Shared constants and FSM state type for the sequential binary-to-BCD converter.
package bcd_pkg;

    localparam logic [3:0] SIGN_MINUS  = 4'hE;
    localparam logic [3:0] SIGN_BLANK  = 4'hF;
    localparam logic [3:0] DIGIT_BLANK = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FORMAT
    } state_t;

endpackage

// File: rtl/bcd_add3.sv
// Per-digit double-dabble correction: digits of 5 or more get +3 before the shift.
module bcd_add3 (
    input  logic [3:0] d,
    output logic [3:0] q
);

    always_comb begin
        q = (d >= 4'd5) ? d + 4'd3 : d;
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with sign nibble, overflow flag
// and optional leading-zero blanking; one magnitude bit per clock.
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int unsigned BIN_W  = 21,
    parameter int unsigned DIGITS = 7,
    parameter int unsigned SIGNED = 1,
    parameter int unsigned BLANK  = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [BIN_W-1:0]        bin,
    output logic                    ready,
    output logic                    valid,
    output logic [4*(DIGITS+1)-1:0] bcd,
    output logic                    neg,
    output logic                    ovf
);

    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    state_t                  state;
    logic [BIN_W-1:0]        mag;
    logic [BIN_W-1:0]        mag_in;
    logic [4*DIGITS-1:0]     scratch;
    logic [4*DIGITS-1:0]     adj;
    logic [4*DIGITS-1:0]     fmt;
    logic [CNT_W-1:0]        cnt;
    logic                    sticky;
    logic                    sign_q;
    logic                    zero_q;
    logic                    lead;
    logic [3:0]              sign_nib;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .d (scratch[4*g +: 4]),
            .q (adj[4*g +: 4])
        );
    end

    // Negation in BIN_W bits maps the most-negative input onto 2^(BIN_W-1) exactly.
    always_comb begin
        mag_in = bin;
        if (SIGNED != 0 && bin[BIN_W-1]) begin
            mag_in = '0 - bin;
        end
    end

    always_comb begin
        fmt  = scratch;
        lead = 1'b1;
        if (BLANK != 0) begin
            for (int unsigned i = 0; i < DIGITS - 1; i++) begin
                if (lead && scratch[4*(DIGITS-1-i) +: 4] == 4'd0) begin
                    fmt[4*(DIGITS-1-i) +: 4] = DIGIT_BLANK;
                end else begin
                    lead = 1'b0;
                end
            end
        end
    end

    always_comb begin
        sign_nib = (SIGNED != 0 && sign_q && !zero_q) ? SIGN_MINUS : SIGN_BLANK;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            mag     <= '0;
            scratch <= '0;
            cnt     <= '0;
            sticky  <= 1'b0;
            sign_q  <= 1'b0;
            zero_q  <= 1'b0;
            ready   <= 1'b1;
            valid   <= 1'b0;
            bcd     <= {SIGN_BLANK, {(4*DIGITS){1'b0}}};
            neg     <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mag     <= mag_in;
                        sign_q  <= (SIGNED != 0) && bin[BIN_W-1];
                        zero_q  <= (bin == '0);
                        scratch <= '0;
                        cnt     <= '0;
                        sticky  <= 1'b0;
                        ready   <= 1'b0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Carry out of the top digit is a 10^DIGITS overflow; digits keep the residue.
                    {scratch, mag} <= {adj[4*DIGITS-2:0], mag, 1'b0};
                    sticky         <= sticky | adj[4*DIGITS-1];
                    cnt            <= cnt + 1'b1;
                    if (cnt == CNT_W'(BIN_W - 1)) begin
                        state <= FORMAT;
                    end
                end
                FORMAT: begin
                    bcd   <= {sign_nib, fmt};
                    neg   <= sign_q && !zero_q;
                    ovf   <= sticky;
                    valid <= 1'b1;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: default, blanking and narrow overflow configurations.
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a, start_b, start_c;
    logic [20:0] bin_a, bin_b;
    logic [9:0]  bin_c;
    logic        ready_a, ready_b, ready_c;
    logic        valid_a, valid_b, valid_c;
    logic [31:0] bcd_a, bcd_b;
    logic [15:0] bcd_c;
    logic        neg_a, neg_b, neg_c;
    logic        ovf_a, ovf_b, ovf_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bin2bcd_seq u_dflt (
        .clk(clk), .rst(rst), .start(start_a), .bin(bin_a), .ready(ready_a),
        .valid(valid_a), .bcd(bcd_a), .neg(neg_a), .ovf(ovf_a)
    );

    bin2bcd_seq #(.BLANK(1)) u_blank (
        .clk(clk), .rst(rst), .start(start_b), .bin(bin_b), .ready(ready_b),
        .valid(valid_b), .bcd(bcd_b), .neg(neg_b), .ovf(ovf_b)
    );

    bin2bcd_seq #(.BIN_W(10), .DIGITS(3), .SIGNED(0)) u_small (
        .clk(clk), .rst(rst), .start(start_c), .bin(bin_c), .ready(ready_c),
        .valid(valid_c), .bcd(bcd_c), .neg(neg_c), .ovf(ovf_c)
    );

    // Launch one conversion on the selected instance; lat = edges from accept to valid, -1 on timeout.
    task automatic run(input int sel, input logic [20:0] b, output int lat);
        @(negedge clk);
        case (sel)
            0: begin start_a = 1'b1; bin_a = b; end
            1: begin start_b = 1'b1; bin_b = b; end
            default: begin start_c = 1'b1; bin_c = b[9:0]; end
        endcase
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if ((sel == 0 && valid_a) || (sel == 1 && valid_b) || (sel == 2 && valid_c)) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        bin_a = '0; bin_b = '0; bin_c = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (ready_a !== 1'b1 || valid_a !== 1'b0) begin
            errors++; $display("FAIL reset_hs got ready=%b valid=%b exp ready=1 valid=0", ready_a, valid_a);
        end
        checks++;
        if (bcd_a !== 32'hF0000000 || neg_a !== 1'b0 || ovf_a !== 1'b0) begin
            errors++; $display("FAIL reset_out got bcd=%h neg=%b ovf=%b exp F0000000 0 0", bcd_a, neg_a, ovf_a);
        end
        checks++;
        if (bcd_c !== 16'hF000 || ready_c !== 1'b1) begin
            errors++; $display("FAIL reset_small got bcd=%h ready=%b exp F000 1", bcd_c, ready_c);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat;
        run(0, 21'd12345, lat);
        checks++;
        if (lat !== 22) begin
            errors++; $display("FAIL basic_latency got %0d exp 22", lat);
        end
        checks++;
        if (bcd_a !== 32'hF0012345 || neg_a !== 1'b0 || ovf_a !== 1'b0) begin
            errors++; $display("FAIL basic_12345 got bcd=%h neg=%b ovf=%b exp F0012345 0 0", bcd_a, neg_a, ovf_a);
        end
        @(posedge clk);
        #1;
        checks++;
        if (valid_a !== 1'b0 || bcd_a !== 32'hF0012345) begin
            errors++; $display("FAIL basic_hold got valid=%b bcd=%h exp 0 F0012345", valid_a, bcd_a);
        end
        run(0, 21'h1FFFFF, lat);
        checks++;
        if (lat !== 22 || bcd_a !== 32'hE0000001 || neg_a !== 1'b1) begin
            errors++; $display("FAIL basic_m1 got lat=%0d bcd=%h neg=%b exp 22 E0000001 1", lat, bcd_a, neg_a);
        end
        run(0, 21'h100000, lat);
        checks++;
        if (bcd_a !== 32'hE1048576 || neg_a !== 1'b1 || ovf_a !== 1'b0) begin
            errors++; $display("FAIL basic_minneg got bcd=%h neg=%b ovf=%b exp E1048576 1 0", bcd_a, neg_a, ovf_a);
        end
    endtask

    task automatic test_blank();
        int lat;
        run(1, 21'h1FFFD6, lat);
        checks++;
        if (lat !== 22 || bcd_b !== 32'hEFFFFF42 || neg_b !== 1'b1) begin
            errors++; $display("FAIL blank_m42 got lat=%0d bcd=%h neg=%b exp 22 EFFFFF42 1", lat, bcd_b, neg_b);
        end
        run(1, 21'd0, lat);
        checks++;
        if (bcd_b !== 32'hFFFFFFF0 || neg_b !== 1'b0) begin
            errors++; $display("FAIL blank_zero got bcd=%h neg=%b exp FFFFFFF0 0", bcd_b, neg_b);
        end
        run(1, 21'd100200, lat);
        checks++;
        if (bcd_b !== 32'hFF100200) begin
            errors++; $display("FAIL blank_inner got bcd=%h exp FF100200", bcd_b);
        end
    endtask

    task automatic test_overflow();
        int lat;
        run(2, 21'd1000, lat);
        checks++;
        if (lat !== 11 || ovf_c !== 1'b1 || bcd_c !== 16'hF000) begin
            errors++; $display("FAIL ovf_1000 got lat=%0d ovf=%b bcd=%h exp 11 1 F000", lat, ovf_c, bcd_c);
        end
        run(2, 21'd999, lat);
        checks++;
        if (ovf_c !== 1'b0 || bcd_c !== 16'hF999) begin
            errors++; $display("FAIL ovf_999 got ovf=%b bcd=%h exp 0 F999", ovf_c, bcd_c);
        end
        run(2, 21'd1023, lat);
        checks++;
        if (ovf_c !== 1'b1 || bcd_c !== 16'hF023 || neg_c !== 1'b0) begin
            errors++; $display("FAIL ovf_1023 got ovf=%b bcd=%h neg=%b exp 1 F023 0", ovf_c, bcd_c, neg_c);
        end
    endtask

    task automatic test_ignore_start();
        int nvalid = 0;
        logic [31:0] last = '0;
        @(negedge clk);
        start_a = 1'b1;
        bin_a = 21'd500;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (k == 5) begin bin_a = 21'd777; start_a = 1'b1; end
            if (k == 6) start_a = 1'b0;
            if (valid_a) begin nvalid++; last = bcd_a; end
        end
        checks++;
        if (nvalid !== 1 || last !== 32'hF0000500) begin
            errors++; $display("FAIL ignore_start got valids=%0d bcd=%h exp 1 F0000500", nvalid, last);
        end
    endtask

    task automatic test_back_to_back();
        int lat1 = -1;
        int lat2 = -1;
        @(negedge clk);
        start_a = 1'b1;
        bin_a = 21'd100;
        @(posedge clk);
        #1;
        checks++;
        if (ready_a !== 1'b0) begin
            errors++; $display("FAIL b2b_busy got ready=%b exp 0", ready_a);
        end
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (valid_a) begin lat1 = k; break; end
        end
        checks++;
        if (lat1 !== 22 || bcd_a !== 32'hF0000100 || ready_a !== 1'b1) begin
            errors++; $display("FAIL b2b_first got lat=%0d bcd=%h ready=%b exp 22 F0000100 1", lat1, bcd_a, ready_a);
        end
        bin_a = 21'd200;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        checks++;
        if (ready_a !== 1'b0 || valid_a !== 1'b0) begin
            errors++; $display("FAIL b2b_accept got ready=%b valid=%b exp 0 0", ready_a, valid_a);
        end
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (valid_a) begin lat2 = k; break; end
        end
        checks++;
        if (lat2 !== 22 || bcd_a !== 32'hF0000200) begin
            errors++; $display("FAIL b2b_second got lat=%0d bcd=%h exp 22 F0000200", lat2, bcd_a);
        end
    endtask

    task automatic test_mid_reset();
        int nvalid = 0;
        int lat;
        @(negedge clk);
        start_a = 1'b1;
        bin_a = 21'd54321;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (ready_a !== 1'b1 || valid_a !== 1'b0 || bcd_a !== 32'hF0000000) begin
            errors++; $display("FAIL midrst_out got ready=%b valid=%b bcd=%h exp 1 0 F0000000", ready_a, valid_a, bcd_a);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (valid_a) nvalid++;
        end
        checks++;
        if (nvalid !== 0) begin
            errors++; $display("FAIL midrst_novalid got %0d valids exp 0", nvalid);
        end
        run(0, 21'd7, lat);
        checks++;
        if (lat !== 22 || bcd_a !== 32'hF0000007) begin
            errors++; $display("FAIL midrst_after got lat=%0d bcd=%h exp 22 F0000007", lat, bcd_a);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_blank();
        test_overflow();
        test_ignore_start();
        test_back_to_back();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
